// File: rtl/param_counter.sv
// Modulo-MOD_VAL up/down counter with clear, clamped load and a wrap event pulse.
// Define PARAM_COUNTER_SATURATE_EN to hold at the bounds (evt on each blocked step) instead of wrapping.
module param_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MOD_VAL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] out,
    output logic             evt
);

    // One extra bit so MOD_VAL-1 and count+1 are representable when MOD_VAL = 2^WIDTH.
    localparam logic [WIDTH:0] MAX_V = (WIDTH + 1)'(MOD_VAL - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   lv_ext;

    assign inc    = {1'b0, cnt_q} + 1'b1;
    assign lv_ext = {1'b0, load_val};

    always_comb begin
        cnt_d = cnt_q;
        evt_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (lv_ext > MAX_V) ? MAX_V[WIDTH-1:0] : load_val;
        end else if (en) begin
            if (up) begin
                if (inc > MAX_V) begin
                    evt_d = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = '0;
`endif
                end else begin
                    cnt_d = inc[WIDTH-1:0];
                end
            end else begin
                if (cnt_q == '0) begin
                    evt_d = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = MAX_V[WIDTH-1:0];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign out = cnt_q;
    assign evt = evt_q;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboarded directed/random bench for param_counter at MOD_VAL = 10, 16 and 2 (WIDTH = 4).
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [3:0] load_val;
    logic [3:0] out10, out16, out2;
    logic       evt10, evt16, evt2;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .MOD_VAL(10)) u10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .out(out10), .evt(evt10));
    param_counter #(.WIDTH(4), .MOD_VAL(16)) u16 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .out(out16), .evt(evt16));
    param_counter #(.WIDTH(4), .MOD_VAL(2)) u2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .out(out2), .evt(evt2));

    typedef struct {
        logic [3:0] o10, o16, o2;
        logic       e10, e16, e2;
    } exp_t;

    exp_t sb[$];
    int   m10, m16, m2;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int cur, input int modv, output int nxt, output logic ev);
        ev  = 1'b0;
        nxt = cur;
        if (clr) nxt = 0;
        else if (load) nxt = (int'(load_val) > modv - 1) ? modv - 1 : int'(load_val);
        else if (en) begin
            if (up) begin
                if (cur == modv - 1) begin
                    ev = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
                    nxt = cur;
`else
                    nxt = 0;
`endif
                end else nxt = cur + 1;
            end else begin
                if (cur == 0) begin
                    ev = 1'b1;
`ifdef PARAM_COUNTER_SATURATE_EN
                    nxt = cur;
`else
                    nxt = modv - 1;
`endif
                end else nxt = cur - 1;
            end
        end
    endfunction

    task automatic cycle(input string tag, input logic c, input logic l, input logic [3:0] lv,
                         input logic e, input logic u);
        exp_t x;
        logic ev;
        int   n;
        clr = c; load = l; load_val = lv; en = e; up = u;
        model(m10, 10, n, ev); m10 = n; x.o10 = 4'(m10); x.e10 = ev;
        model(m16, 16, n, ev); m16 = n; x.o16 = 4'(m16); x.e16 = ev;
        model(m2,  2,  n, ev); m2  = n; x.o2  = 4'(m2);  x.e2  = ev;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".out10"}, out10, x.o10);
        chk({tag, ".evt10"}, {3'b0, evt10}, {3'b0, x.e10});
        chk({tag, ".out16"}, out16, x.o16);
        chk({tag, ".evt16"}, {3'b0, evt16}, {3'b0, x.e16});
        chk({tag, ".out2"},  out2,  x.o2);
        chk({tag, ".evt2"},  {3'b0, evt2},  {3'b0, x.e2});
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out10"}, out10, 4'd0);
        chk({tag, ".evt10"}, {3'b0, evt10}, 4'd0);
        chk({tag, ".out16"}, out16, 4'd0);
        chk({tag, ".evt16"}, {3'b0, evt16}, 4'd0);
        chk({tag, ".out2"},  out2,  4'd0);
        chk({tag, ".evt2"},  {3'b0, evt2},  4'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = 4'd0;
        m10 = 0; m16 = 0; m2 = 0;
        #2;
        chk_all_zero("reset_async");
        @(negedge clk);
        rst = 1'b0;

        // 12 up steps from 0: mod10 wraps on the 10th, mod2 wraps every other edge
        for (int i = 0; i < 12; i++) cycle("up_run", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        // asynchronous reset between edges with out=7, then held across an enabled edge
        cycle("load7", 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        chk("pre_rst.out10", out10, 4'd7);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'd5;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        m10 = 0; m16 = 0; m2 = 0;

        // clamped load, then down-wrap from 0
        cycle("load13", 1'b0, 1'b1, 4'd13, 1'b0, 1'b0);
        cycle("clr", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        cycle("down_wrap", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle("down", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        cycle("dir_flip", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cycle("hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // priority clr > load > en
        cycle("load5", 1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
        cycle("clr_pri", 1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        cycle("load_pri", 1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
        cycle("load_bound", 1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
        cycle("load_zero", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

        // upper bound from 8: wrap or saturate depending on build
        cycle("load8", 1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("up_from8", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

        // full-range modulus: 15 -> 0 on the MOD_VAL=16 instance
        cycle("load15", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
        cycle("wrap16", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        cycle("clr0", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("down_from0", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++)
            cycle("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
